// File: rtl/rank_select_if.sv
`default_nettype none
// ============================================================================
// Module      : rank_select_if
// Description : Handshake/data bundle for rank_select. The master side is the
//               producer/consumer pair around the block; the slave side is
//               rank_select itself. out_min/out_max exist only when
//               RANK_SELECT_MINMAX_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface rank_select_if #(
  parameter int DATA_BITS = 8,
  parameter int RANK_BITS = 2,
  parameter int N         = 3
);
  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_BITS*N-1:0]   s;
  logic [RANK_BITS*N-1:0]   ranks;
  logic [RANK_BITS-1:0]     target_rank;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_BITS-1:0]     out_data;
  logic                     err;
  logic                     err_clr;
`ifdef RANK_SELECT_MINMAX_EN
  logic [DATA_BITS-1:0]     out_min;
  logic [DATA_BITS-1:0]     out_max;

  modport master (
    output in_valid, s, ranks, target_rank, out_ready, err_clr,
    input  in_ready, out_valid, out_data, err, out_min, out_max
  );

  modport slave (
    input  in_valid, s, ranks, target_rank, out_ready, err_clr,
    output in_ready, out_valid, out_data, err, out_min, out_max
  );
`else
  modport master (
    output in_valid, s, ranks, target_rank, out_ready, err_clr,
    input  in_ready, out_valid, out_data, err
  );

  modport slave (
    input  in_valid, s, ranks, target_rank, out_ready, err_clr,
    output in_ready, out_valid, out_data, err
  );
`endif
endinterface
`default_nettype wire

// File: rtl/rank_select.sv
`default_nettype none
// ============================================================================
// Module      : rank_select
// Description : Two-stage order-statistic selector. Given a window of N
//               samples and the rank of each, returns the sample whose rank
//               equals the (clamped) requested target. S1 captures samples
//               and a one-hot match vector; S2 muxes the selected sample.
//               A sticky err flags zero or multiple matches.
// Options     : RANK_SELECT_MINMAX_EN - adds out_min (rank 0) and out_max
//               (rank N-1), pipelined alongside out_data.
// Revision    : 1.0 - initial release
// ============================================================================
module rank_select #(
  parameter int DATA_BITS = 8,
  parameter int RANK_BITS = 2,
  parameter int N         = 3
) (
  input  logic             clk,
  input  logic             rst,
  rank_select_if.slave     bus
);

  // N widened by one bit so a RANK_BITS-wide target can be compared against
  // it even when N == 2**RANK_BITS.
  localparam logic [RANK_BITS:0]   c_n_ext    = (RANK_BITS+1)'(N);
  localparam logic [RANK_BITS-1:0] c_max_rank = RANK_BITS'(N-1);

  // One-hot (ideally) vector of samples whose rank equals t.
  function automatic logic [N-1:0] match_rank(
    input logic [RANK_BITS*N-1:0] r,
    input logic [RANK_BITS-1:0]   t
  );
    logic [N-1:0] m;
    m = '0;
    for (int k = 0; k < N; k++) begin
      m[k] = (r[k*RANK_BITS +: RANK_BITS] == t);
    end
    return m;
  endfunction

  // Lowest-index matching sample; sample 0 when nothing matches.
  function automatic logic [DATA_BITS-1:0] pick_lowest(
    input logic [N-1:0]           m,
    input logic [DATA_BITS*N-1:0] smp
  );
    logic [DATA_BITS-1:0] v;
    v = smp[DATA_BITS-1:0];
    for (int k = N-1; k >= 0; k--) begin
      if (m[k]) begin
        v = smp[k*DATA_BITS +: DATA_BITS];
      end
    end
    return v;
  endfunction

  // Pipeline registers
  logic                   r_s1_valid;
  logic [DATA_BITS*N-1:0] r_s1_samples;
  logic [N-1:0]           r_s1_match;
  logic                   r_s2_valid;
  logic [DATA_BITS-1:0]   r_out_data;
  logic                   r_err;

  // Combinational control and datapath
  logic                   w_s2_move;
  logic                   w_s1_move;
  logic [RANK_BITS-1:0]   w_target;
  logic [N-1:0]           w_match;
  logic                   w_s1_bad;
  logic [DATA_BITS-1:0]   w_s1_data;
  logic                   w_err_set;

  // S2 can take new data when empty or its result is being consumed; S1 can
  // move when empty or S2 can take its content.
  assign w_s2_move = !r_s2_valid || bus.out_ready;
  assign w_s1_move = !r_s1_valid || w_s2_move;

  // The clamped target is folded directly into the captured match vector,
  // so later target_rank changes cannot affect an accepted window.
  assign w_target = ({1'b0, bus.target_rank} >= c_n_ext) ? c_max_rank
                                                          : bus.target_rank;
  assign w_match  = match_rank(bus.ranks, w_target);

  // Consistent ranks give exactly one match: flag empty or multi-bit vectors.
  assign w_s1_bad  = (r_s1_match == '0) ||
                     ((r_s1_match & (r_s1_match - N'(1))) != '0);
  assign w_s1_data = pick_lowest(r_s1_match, r_s1_samples);
  assign w_err_set = r_s1_valid && w_s2_move && w_s1_bad;

  // S1: capture window samples and match vector on acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid   <= 1'b0;
      r_s1_samples <= '0;
      r_s1_match   <= '0;
    end else if (w_s1_move) begin
      r_s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1_samples <= bus.s;
        r_s1_match   <= w_match;
      end
    end
  end

  // S2: register the selected sample; hold while the consumer stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s2_valid <= 1'b0;
      r_out_data <= '0;
    end else if (w_s2_move) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_data <= w_s1_data;
      end
    end
  end

  // Sticky error: a new error wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end else if (bus.err_clr) begin
      r_err <= 1'b0;
    end
  end

  assign bus.in_ready  = w_s1_move;
  assign bus.out_valid = r_s2_valid;
  assign bus.out_data  = r_out_data;
  assign bus.err       = r_err;

`ifdef RANK_SELECT_MINMAX_EN
  logic [N-1:0]         r_s1_match_min;
  logic [N-1:0]         r_s1_match_max;
  logic [DATA_BITS-1:0] r_out_min;
  logic [DATA_BITS-1:0] r_out_max;

  // S1: match vectors for the fixed ranks 0 and N-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_match_min <= '0;
      r_s1_match_max <= '0;
    end else if (w_s1_move && bus.in_valid) begin
      r_s1_match_min <= match_rank(bus.ranks, '0);
      r_s1_match_max <= match_rank(bus.ranks, c_max_rank);
    end
  end

  // S2: min/max advance in lockstep with out_data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_min <= '0;
      r_out_max <= '0;
    end else if (w_s2_move && r_s1_valid) begin
      r_out_min <= pick_lowest(r_s1_match_min, r_s1_samples);
      r_out_max <= pick_lowest(r_s1_match_max, r_s1_samples);
    end
  end

  assign bus.out_min = r_out_min;
  assign bus.out_max = r_out_max;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rank_select.sv
`default_nettype none
// ============================================================================
// Module      : tb_rank_select
// Description : Directed self-checking bench for rank_select (N=3, 8-bit
//               samples, 2-bit ranks). Also checks out_min/out_max when
//               RANK_SELECT_MINMAX_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rank_select;
  localparam int DB = 8;
  localparam int RB = 2;
  localparam int NN = 3;

  localparam logic [DB*NN-1:0] c_s      = {8'd30, 8'd10, 8'd20};
  localparam logic [RB*NN-1:0] c_rk_ok  = {2'd2, 2'd0, 2'd1};
  localparam logic [RB*NN-1:0] c_rk_bad = {2'd1, 2'd1, 2'd0};

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  rank_select_if #(.DATA_BITS(DB), .RANK_BITS(RB), .N(NN)) bus ();

  rank_select #(.DATA_BITS(DB), .RANK_BITS(RB), .N(NN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample handshakes mid-cycle, return just after the edge.
  task automatic cyc(output logic acc, output logic oacc, output logic rdy,
                     output logic [DB-1:0] od);
    @(negedge clk);
    rdy  = bus.in_ready;
    acc  = bus.in_valid && bus.in_ready;
    oacc = bus.out_valid && bus.out_ready;
    od   = bus.out_data;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic          acc, oacc, rdy;
    logic [DB-1:0] od;
    logic [RB-1:0] tg [4];
    logic [DB-1:0] ex [4];
    int            ni, no, tcount, stale;

    tg = '{2'd0, 2'd1, 2'd2, 2'd3};
    ex = '{8'd10, 8'd20, 8'd30, 8'd30};

    bus.in_valid    = 1'b0;
    bus.s           = c_s;
    bus.ranks       = c_rk_ok;
    bus.target_rank = '0;
    bus.out_ready   = 1'b1;
    bus.err_clr     = 1'b0;

    // Reset state
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data",  bus.out_data,  0);
    chk("rst_err",       bus.err,       0);
    chk("rst_in_ready",  bus.in_ready,  1);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Median: target 1 selects 20, result two cycles after acceptance
    bus.in_valid    = 1'b1;
    bus.target_rank = 2'd1;
    cyc(acc, oacc, rdy, od);
    chk("med_accept", acc, 1);
    bus.in_valid    = 1'b0;
    bus.target_rank = 2'd0;
    chk("med_lat1_valid", bus.out_valid, 0);
    cyc(acc, oacc, rdy, od);
    chk("med_valid", bus.out_valid, 1);
    chk("med_data",  bus.out_data,  20);
`ifdef RANK_SELECT_MINMAX_EN
    chk("med_min", bus.out_min, 10);
    chk("med_max", bus.out_max, 30);
`endif
    cyc(acc, oacc, rdy, od);
    chk("med_drain", bus.out_valid, 0);

    // Clamp: target 3 -> rank 2 (30); target change after acceptance ignored
    bus.in_valid    = 1'b1;
    bus.target_rank = 2'd3;
    cyc(acc, oacc, rdy, od);
    bus.in_valid    = 1'b0;
    bus.target_rank = 2'd0;
    cyc(acc, oacc, rdy, od);
    chk("clamp_valid", bus.out_valid, 1);
    chk("clamp_data",  bus.out_data,  30);
    cyc(acc, oacc, rdy, od);

    // Backpressure: five stalled cycles with in_valid held
    bus.out_ready = 1'b0;
    ni = 0;
    for (int c = 0; c < 5; c++) begin
      bus.in_valid    = 1'b1;
      bus.target_rank = tg[ni];
      cyc(acc, oacc, rdy, od);
      chk($sformatf("bp_ready%0d", c), rdy, (c < 2) ? 1 : 0);
      if (acc) ni++;
      if (c >= 1) begin
        chk($sformatf("bp_hold_valid%0d", c), bus.out_valid, 1);
        chk($sformatf("bp_hold_data%0d", c),  bus.out_data,  10);
      end
    end
    chk("bp_accepts", ni, 2);

    // Release: remaining inputs flow, results in order, one per cycle
    bus.out_ready = 1'b1;
    no = 0;
    tcount = 0;
    for (int t = 0; t < 20 && no < 4; t++) begin
      bus.in_valid    = (ni < 4);
      bus.target_rank = tg[(ni < 4) ? ni : 3];
      cyc(acc, oacc, rdy, od);
      tcount++;
      if (acc) ni++;
      if (oacc) begin
        chk($sformatf("bp_order%0d", no), od, ex[no]);
        no++;
      end
    end
    bus.in_valid = 1'b0;
    chk("bp_count",      no,     4);
    chk("bp_throughput", tcount, 4);
    chk("bp_empty",      bus.out_valid, 0);

    // Error: no match for target 2 -> sample 0, err set
    bus.ranks       = c_rk_bad;
    bus.target_rank = 2'd2;
    bus.in_valid    = 1'b1;
    chk("err_pre", bus.err, 0);
    cyc(acc, oacc, rdy, od);
    bus.in_valid = 1'b0;
    cyc(acc, oacc, rdy, od);
    chk("err_nm_valid", bus.out_valid, 1);
    chk("err_nm_data",  bus.out_data,  20);
    chk("err_nm_flag",  bus.err,       1);
    bus.err_clr = 1'b1;
    cyc(acc, oacc, rdy, od);
    bus.err_clr = 1'b0;
    chk("err_cleared", bus.err, 0);

    // Multi-match (ranks k1,k2 both 1) with err_clr on the same edge
    bus.target_rank = 2'd1;
    bus.in_valid    = 1'b1;
    cyc(acc, oacc, rdy, od);
    bus.in_valid = 1'b0;
    bus.err_clr  = 1'b1;
    cyc(acc, oacc, rdy, od);
    bus.err_clr  = 1'b0;
    chk("err_mm_valid", bus.out_valid, 1);
    chk("err_mm_data",  bus.out_data,  10);
    chk("err_mm_prec",  bus.err,       1);
    cyc(acc, oacc, rdy, od);
    chk("err_sticky", bus.err, 1);

    // Reset with two results in flight
    bus.ranks       = c_rk_ok;
    bus.out_ready   = 1'b0;
    bus.in_valid    = 1'b1;
    bus.target_rank = 2'd1;
    cyc(acc, oacc, rdy, od);
    cyc(acc, oacc, rdy, od);
    bus.in_valid = 1'b0;
    chk("rmid_inflight", bus.out_valid, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("rmid_out_valid", bus.out_valid, 0);
    chk("rmid_err",       bus.err,       0);
    chk("rmid_in_ready",  bus.in_ready,  1);
    chk("rmid_out_data",  bus.out_data,  0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.out_ready = 1'b1;
    stale = 0;
    for (int t = 0; t < 4; t++) begin
      cyc(acc, oacc, rdy, od);
      if (bus.out_valid !== 1'b0) stale++;
    end
    chk("rmid_no_stale", stale, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rank_select.md
RANK_SELECT -- requirements
Module: rank_select

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, the sample width.
REQ-002 SHALL have parameter RANK_BITS, default 2, the rank width.
REQ-003 SHALL have parameter N, default 3, the window length; N <= 2^RANK_BITS.
REQ-004 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  window sample and ranks present.
REQ-007 SHALL have port in_ready  output  1  block accepts the current input.
REQ-008 SHALL have port s  input  DATA_BITS*N  window samples; sample k at bits [k*DATA_BITS +: DATA_BITS].
REQ-009 SHALL have port ranks  input  RANK_BITS*N  rank of each sample k, same packing; rank 0 is the smallest.
REQ-010 SHALL have port target_rank  input  RANK_BITS  requested order statistic.
REQ-011 SHALL have port out_valid  output  1  out_data holds a result.
REQ-012 SHALL have port out_ready  input  1  consumer accepts out_data.
REQ-013 SHALL have port out_data  output  DATA_BITS  selected sample.
REQ-014 SHALL have port err  output  1  sticky rank-consistency error.
REQ-015 SHALL have port err_clr  input  1  clears err.

Function
REQ-016 SHALL accept an input on a cycle where in_valid && in_ready.
REQ-017 SHALL form a two-stage pipeline:
- S1 registers the samples, the clamped target, and a one-hot match vector (ranks[k] == target).
- S2 registers the muxed sample into out_data.
REQ-018 SHALL clamp target_rank >= N to N-1 at acceptance.
REQ-019 SHALL sample target_rank only at acceptance; later changes do not affect results in flight.
REQ-020 SHALL assert out_valid exactly 2 cycles after acceptance when there is no backpressure.
REQ-021 SHALL drive in_ready = !s1_valid || !s2_valid || out_ready, i.e. S1 can move.
REQ-022 SHALL hold out_data and out_valid stable while out_valid && !out_ready.
REQ-023 SHALL sustain one result per cycle while out_ready is held high.
REQ-024 SHALL detect zero matches or more than one match in S1:
- select the lowest matching index, or 0 when there is no match;
- set err when that result moves to S2.
REQ-025 SHALL give the err set precedence over err_clr when both occur in the same cycle.
REQ-026 SHALL neither drop nor duplicate results under any in_valid/out_ready pattern.

Reset
REQ-027 SHALL, while rst is low, clear s1_valid, out_valid, out_data and err to 0 asynchronously.
REQ-028 SHALL drive in_ready = 1 after reset.
REQ-029 SHALL discard any data in flight when reset is asserted mid-operation.

Configuration
REQ-030 SHALL, when macro RANK_SELECT_MINMAX_EN is defined, add output ports out_min and out_max, each DATA_BITS wide.
- out_min is the sample with rank 0; out_max is the sample with rank N-1.
- Both are pipelined and qualified identically to out_data, with reset value 0.
REQ-031 SHALL, without RANK_SELECT_MINMAX_EN, omit out_min, out_max and their logic entirely.

Verification
REQ-032 SHALL cover the median case: N=3, s={30,10,20} (k2..k0), ranks={2,0,1}, target=1, out_ready=1 -> out_data=20, out_valid exactly 2 cycles after acceptance.
REQ-033 SHALL cover backpressure: out_ready=0 for 5 cycles with in_valid held -> in_ready drops after 2 accepts, out_data is held, and after release the results appear in order with none lost.
REQ-034 SHALL cover clamping: target=3 with N=3 -> selects the rank-2 sample (30 in REQ-032 data).
REQ-035 SHALL cover the error path: ranks={1,1,0}, target=2 -> out_data=s[0], err=1; err_clr pulse -> err=0; err_clr coinciding with a new error -> err stays 1.
REQ-036 SHALL cover reset mid-stream: rst low with 2 results in flight -> out_valid=0, err=0, in_ready=1, and no stale output after release.
REQ-037 SHALL cover the MINMAX build, with RANK_SELECT_MINMAX_EN defined and the REQ-032 stimulus -> out_min=10, out_max=30, alongside out_data=20.
